fifo_s1_df_gen: RTL and testbench
=================================

# fifo_s1_df_gen

Next-generation single-clock FIFO controller with dynamic flags and integrated storage. Generalises the existing synchronous dynamic-flag FIFO:
- any depth, not just powers of two, with explicit pointer wrap;
- selectable show-ahead (first-word-fall-through) output;
- a live word count;
- a synchronous flush;
- a selectable error policy.

It sits between a producer and a consumer in one clock domain, used as the standard elastic buffer for datapath blocks.

## Interface
- WIDTH, 8, data word width (1..256)
- DEPTH, 4, number of words (2..256, any integer)
- ERR_MODE, 0, 0 = sticky error (cleared by rst or diag_n), 1 = error pulses one cycle per offending request
- SHOW_AHEAD, 0, 0 = registered output updated on pop, 1 = head word visible on data_out whenever not empty
- CNT_W, clog2(DEPTH+1), derived: count/threshold width, not overridden

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- push_req_n  in  1  push request, active low
- pop_req_n  in  1  pop request, active low
- flush  in  1  synchronous clear of contents, active high
- diag_n  in  1  clears sticky error when low (ERR_MODE 0), active low
- ae_level  in  CNT_W  almost-empty level
- af_thresh  in  CNT_W  almost-full threshold
- data_in  in  WIDTH  push data
- empty  out  1  count == 0
- almost_empty  out  1  count <= ae_level
- half_full  out  1  count >= (DEPTH+1)/2
- almost_full  out  1  count >= af_thresh
- full  out  1  count == DEPTH
- error  out  1  overflow/underflow indication
- word_count  out  CNT_W  current occupancy
- data_out  out  WIDTH  read data

## Operation
- **Pop accepted**: pop_req_n=0 and !empty.
- **Push accepted**: push_req_n=0 and (!full or pop accepted same cycle).
- **Full with push+pop**: both accepted; count unchanged.
- **Empty with push+pop**: push accepted; pop is an underflow (no bypass). Count becomes 1; error as per ERR_MODE.
- **Overflow**: push while full with no pop. Data dropped, state unchanged, error event.
- **Underflow**: pop while empty. Pointers unchanged, data_out unchanged, error event.
- **Pointers**: wr_ptr and rd_ptr range 0..DEPTH-1; increment wraps DEPTH-1 -> 0 (compare, not modulo-2^n). Count is tracked explicitly, not derived from pointers.
- **flush=1**: pointers and count go to 0 next edge. Overrides push/pop in the same cycle; that push/pop is neither performed nor counted as an error. error and data_out are unaffected.
- **Flags**: all five derive from the post-edge count and are registered (no combinational path from requests). Threshold inputs are sampled live each cycle.
- **ERR_MODE 0**: error sets on any overflow/underflow and holds. Cleared by rst or diag_n=0; diag_n=0 in the same cycle as a new error leaves error set.
- **ERR_MODE 1**: error=1 for exactly the cycle after an offending request; diag_n ignored.
- **SHOW_AHEAD 0**: data_out loads mem[rd_ptr] at the edge of an accepted pop and holds otherwise.
- **SHOW_AHEAD 1**: data_out = mem[rd_ptr] combinationally. Valid only when !empty, don't-care when empty.

## Timing
- **Reset values**: empty=1, almost_empty=1, half_full=0, almost_full=0, full=0, error=0, word_count=0, data_out=0. Storage is not reset.
- **Reset priority**: rst mid-operation discards all contents in one cycle and has priority over flush, push and pop.
- **Latency, push to visible**: 1 cycle. Word pushed at edge N: empty falls after N; in SHOW_AHEAD 1 it appears on data_out after N.
- **Latency, pop to data (SHOW_AHEAD 0)**: pop at edge N presents the word after N.
- **Throughput**: one push and one pop per cycle, sustained.

## Structure
- **Package fifo_s1_pkg**:
  - clog2 function;
  - ERR_STICKY/ERR_PULSE constants;
  - ptr_incr function with DEPTH-aware wrap.
- **Sub-module fifo_s1_ram**: DEPTH x WIDTH, one synchronous write port, one asynchronous read port, no reset.
- **Top level**: pointer/count/flag/error logic and the output register.

## Test plan
- **Reset/fill/drain**: DEPTH=4. After rst, push 0x11,0x22,0x33,0x44 -> full=1, word_count=4; 4 pops -> data_out 0x11..0x44 in order; empty=1.
- **Non-power-of-2 wrap**: DEPTH=5. Interleave 12 pushes of incrementing data with pops, keeping count at 2..3 -> pointers wrap 4->0 twice; output sequence exact, no gaps.
- **Error policy**:
  - ERR_MODE 0: push on full -> error=1, sticky; word_count stays 4. diag_n=0 one cycle -> error=0.
  - ERR_MODE 1: pop on empty -> error high exactly one cycle.
- **Simultaneous events**:
  - Push+pop on full -> count stays 4, no error.
  - Push+pop on empty -> count=1, error set.
  - Flush with push -> count=0, no error.
- **Flags**: DEPTH=8, ae_level=2, af_thresh=6. Step count 0..8 -> almost_empty for 0..2, half_full from 4, almost_full from 6, full at 8, each one cycle after the causing push.
- **SHOW_AHEAD 1**: push 0xA5 into empty -> data_out=0xA5 the cycle after, with no pop. rst asserted with 3 words held -> next cycle empty=1, word_count=0.

Source files
------------

// File: rtl/fifo_s1_pkg.sv
// fifo_s1_pkg: shared constants and helpers for the single-clock dynamic-flag FIFO
package fifo_s1_pkg;
  localparam int ERR_STICKY = 0;
  localparam int ERR_PULSE = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int ptr_incr(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/fifo_s1_df_gen_if.sv
// fifo_s1_df_gen_if: producer/consumer request, threshold, flag and data bundle
interface fifo_s1_df_gen_if import fifo_s1_pkg::*; #(parameter int WIDTH = 8, parameter int DEPTH = 4);
  localparam int CNT_W = clog2(DEPTH + 1);
  logic push_req_n, pop_req_n, flush, diag_n;
  logic [CNT_W-1:0] ae_level, af_thresh, word_count;
  logic [WIDTH-1:0] data_in, data_out;
  logic empty, almost_empty, half_full, almost_full, full, error;
  modport master(output push_req_n, pop_req_n, flush, diag_n, ae_level, af_thresh, data_in,
                 input empty, almost_empty, half_full, almost_full, full, error, word_count, data_out);
  modport slave(input push_req_n, pop_req_n, flush, diag_n, ae_level, af_thresh, data_in,
                output empty, almost_empty, half_full, almost_full, full, error, word_count, data_out);
endinterface

// File: rtl/fifo_s1_ram.sv
// fifo_s1_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read, no reset
module fifo_s1_ram #(parameter int WIDTH = 8, parameter int DEPTH = 4, parameter int AW = 2) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo_s1_df_gen.sv
// fifo_s1_df_gen: single-clock FIFO with any depth, live count, flush, registered flags and error policy
module fifo_s1_df_gen import fifo_s1_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ERR_MODE = 0,
  parameter int SHOW_AHEAD = 0
) (
  input logic clk,
  input logic rst,
  fifo_s1_df_gen_if.slave bus
);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam int PTR_W = clog2(DEPTH);
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_dout, w_rdata;
  logic r_empty, r_aempty, r_hfull, r_afull, r_full, r_error;
  logic w_pop, w_push, w_err_ev;
  always_comb begin
    w_pop = !bus.pop_req_n && r_cnt != '0;
    w_push = !bus.push_req_n && (r_cnt != CNT_W'(DEPTH) || w_pop);
    w_err_ev = !bus.flush && ((!bus.push_req_n && !w_push) || (!bus.pop_req_n && r_cnt == '0));
    w_cnt_nxt = bus.flush ? '0 : r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
  end
  fifo_s1_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PTR_W)) u_ram (
    .clk(clk),
    .i_we(w_push && !bus.flush),
    .i_waddr(r_wr_ptr),
    .i_wdata(bus.data_in),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt <= '0;
      r_empty <= 1'b1;
      r_aempty <= 1'b1;
      r_hfull <= 1'b0;
      r_afull <= 1'b0;
      r_full <= 1'b0;
      r_error <= 1'b0;
      r_dout <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_wr_ptr <= bus.flush ? '0 : w_push ? PTR_W'(ptr_incr(int'(r_wr_ptr), DEPTH)) : r_wr_ptr;
      r_rd_ptr <= bus.flush ? '0 : w_pop ? PTR_W'(ptr_incr(int'(r_rd_ptr), DEPTH)) : r_rd_ptr;
      r_empty <= w_cnt_nxt == '0;
      r_aempty <= w_cnt_nxt <= bus.ae_level;
      r_hfull <= w_cnt_nxt >= CNT_W'((DEPTH + 1) / 2);
      r_afull <= w_cnt_nxt >= bus.af_thresh;
      r_full <= w_cnt_nxt == CNT_W'(DEPTH);
      r_error <= (ERR_MODE == ERR_STICKY) ? (w_err_ev | (r_error & bus.diag_n)) : w_err_ev;
      if (w_pop && !bus.flush) r_dout <= w_rdata;
    end
  end
  assign bus.empty = r_empty;
  assign bus.almost_empty = r_aempty;
  assign bus.half_full = r_hfull;
  assign bus.almost_full = r_afull;
  assign bus.full = r_full;
  assign bus.error = r_error;
  assign bus.word_count = r_cnt;
  assign bus.data_out = (SHOW_AHEAD != 0) ? w_rdata : r_dout;
endmodule

// File: tb/tb_fifo_s1_df_gen.sv
// tb_fifo_s1_df_gen: three FIFO configurations on shared stimulus, checked against a queue model
module tb_fifo_s1_df_gen;
  import fifo_s1_pkg::*;
  logic clk = 0, rst = 1, push_n = 1, pop_n = 1, fl = 0, diag_n = 1;
  logic [7:0] din = 0;
  logic [3:0] ae = 0, af = 0;
  int checks = 0, failures = 0;
  int dep [3] = '{4, 5, 8};
  int emode [3] = '{0, 1, 0};
  int sa [3] = '{0, 0, 1};
  logic [7:0] mq [3][$];
  logic merr [3] = '{0, 0, 0};
  logic [7:0] mdout [3] = '{0, 0, 0};
  logic [3:0] mae [3] = '{0, 0, 0};
  logic [3:0] maf [3] = '{0, 0, 0};
  logic [5:0] flg [3];
  logic [3:0] cnt_o [3];
  logic [7:0] dout [3];
  always #5 clk = ~clk;
  fifo_s1_df_gen_if #(.WIDTH(8), .DEPTH(4)) bus0 ();
  fifo_s1_df_gen_if #(.WIDTH(8), .DEPTH(5)) bus1 ();
  fifo_s1_df_gen_if #(.WIDTH(8), .DEPTH(8)) bus2 ();
  fifo_s1_df_gen #(.WIDTH(8), .DEPTH(4), .ERR_MODE(0), .SHOW_AHEAD(0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  fifo_s1_df_gen #(.WIDTH(8), .DEPTH(5), .ERR_MODE(1), .SHOW_AHEAD(0)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  fifo_s1_df_gen #(.WIDTH(8), .DEPTH(8), .ERR_MODE(0), .SHOW_AHEAD(1)) u2 (.clk(clk), .rst(rst), .bus(bus2));
  assign bus0.push_req_n = push_n;
  assign bus0.pop_req_n = pop_n;
  assign bus0.flush = fl;
  assign bus0.diag_n = diag_n;
  assign bus0.data_in = din;
  assign bus0.ae_level = ae[2:0];
  assign bus0.af_thresh = af[2:0];
  assign bus1.push_req_n = push_n;
  assign bus1.pop_req_n = pop_n;
  assign bus1.flush = fl;
  assign bus1.diag_n = diag_n;
  assign bus1.data_in = din;
  assign bus1.ae_level = ae[2:0];
  assign bus1.af_thresh = af[2:0];
  assign bus2.push_req_n = push_n;
  assign bus2.pop_req_n = pop_n;
  assign bus2.flush = fl;
  assign bus2.diag_n = diag_n;
  assign bus2.data_in = din;
  assign bus2.ae_level = ae;
  assign bus2.af_thresh = af;
  assign flg[0] = {bus0.empty, bus0.almost_empty, bus0.half_full, bus0.almost_full, bus0.full, bus0.error};
  assign flg[1] = {bus1.empty, bus1.almost_empty, bus1.half_full, bus1.almost_full, bus1.full, bus1.error};
  assign flg[2] = {bus2.empty, bus2.almost_empty, bus2.half_full, bus2.almost_full, bus2.full, bus2.error};
  assign cnt_o[0] = {1'b0, bus0.word_count};
  assign cnt_o[1] = {1'b0, bus1.word_count};
  assign cnt_o[2] = bus2.word_count;
  assign dout[0] = bus0.data_out;
  assign dout[1] = bus1.data_out;
  assign dout[2] = bus2.data_out;

  task automatic step(input logic pu, input logic po, input logic f, input logic dg, input logic [7:0] d);
    push_n = !pu;
    pop_n = !po;
    fl = f;
    diag_n = dg;
    din = d;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      int n;
      bit pok, puk, ev;
      n = mq[k].size();
      mae[k] = ae;
      maf[k] = af;
      if (rst) begin
        mq[k].delete();
        merr[k] = 0;
        mdout[k] = 0;
      end else if (f) begin
        mq[k].delete();
        merr[k] = (emode[k] == 0) ? (merr[k] & dg) : 1'b0;
      end else begin
        pok = po && n > 0;
        puk = pu && (n < dep[k] || pok);
        ev = (pu && !puk) || (po && n == 0);
        if (pok) mdout[k] = mq[k].pop_front();
        if (puk) mq[k].push_back(d);
        merr[k] = (emode[k] == 1) ? ev : (ev | (merr[k] & dg));
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    step(0, 0, 0, 1, 8'h00);
    rst = 0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 1, 8'h5A);
    step(1, 0, 0, 1, 8'h6B);
    step(0, 1, 0, 1, 8'h00);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (flg[k] !== 6'b110000) begin
        failures++;
        $display("FAIL reset_flags k=%0d got=%b exp=110000", k, flg[k]);
      end
      checks++;
      if (cnt_o[k] !== 4'd0) begin
        failures++;
        $display("FAIL reset_count k=%0d got=%0d exp=0", k, cnt_o[k]);
      end
    end
    checks++;
    if (dout[0] !== 8'h00) begin
      failures++;
      $display("FAIL reset_dout got=%h exp=00", dout[0]);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 1, 8'(i * 8'h11));
    checks++;
    if (flg[0][1] !== 1'b1 || cnt_o[0] !== 4'd4) begin
      failures++;
      $display("FAIL fill full=%b count=%0d exp full=1 count=4", flg[0][1], cnt_o[0]);
    end
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 1, 8'h00);
      checks++;
      if (dout[0] !== 8'(i * 8'h11)) begin
        failures++;
        $display("FAIL drain i=%0d got=%h exp=%h", i, dout[0], 8'(i * 8'h11));
      end
    end
    checks++;
    if (flg[0][5] !== 1'b1) begin
      failures++;
      $display("FAIL drain_empty got=%b exp=1", flg[0][5]);
    end
  endtask

  task automatic test_err_sticky();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 8'(i));
    step(1, 0, 0, 1, 8'hEE);
    checks++;
    if (flg[0][0] !== 1'b1 || cnt_o[0] !== 4'd4) begin
      failures++;
      $display("FAIL overflow err=%b count=%0d exp err=1 count=4", flg[0][0], cnt_o[0]);
    end
    step(0, 0, 0, 1, 8'h00);
    checks++;
    if (flg[0][0] !== 1'b1) begin
      failures++;
      $display("FAIL sticky_hold got=%b exp=1", flg[0][0]);
    end
    step(1, 0, 0, 0, 8'hEE);
    checks++;
    if (flg[0][0] !== 1'b1) begin
      failures++;
      $display("FAIL diag_vs_new_err got=%b exp=1", flg[0][0]);
    end
    step(0, 0, 0, 0, 8'h00);
    checks++;
    if (flg[0][0] !== 1'b0) begin
      failures++;
      $display("FAIL diag_clear got=%b exp=0", flg[0][0]);
    end
  endtask

  task automatic test_err_pulse();
    do_reset();
    step(0, 1, 0, 1, 8'h00);
    checks++;
    if (flg[1][0] !== 1'b1) begin
      failures++;
      $display("FAIL pulse_high got=%b exp=1", flg[1][0]);
    end
    step(0, 0, 0, 1, 8'h00);
    checks++;
    if (flg[1][0] !== 1'b0) begin
      failures++;
      $display("FAIL pulse_low got=%b exp=0", flg[1][0]);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 8'(8'h30 + i));
    step(1, 1, 0, 1, 8'h77);
    checks++;
    if (cnt_o[0] !== 4'd4 || flg[0][0] !== 1'b0 || dout[0] !== 8'h30) begin
      failures++;
      $display("FAIL pushpop_full count=%0d err=%b dout=%h exp 4 0 30", cnt_o[0], flg[0][0], dout[0]);
    end
    do_reset();
    step(1, 1, 0, 1, 8'h99);
    checks++;
    if (cnt_o[0] !== 4'd1 || flg[0][0] !== 1'b1) begin
      failures++;
      $display("FAIL pushpop_empty count=%0d err=%b exp 1 1", cnt_o[0], flg[0][0]);
    end
    do_reset();
    step(1, 0, 0, 1, 8'h01);
    step(1, 0, 0, 1, 8'h02);
    step(1, 0, 1, 1, 8'h03);
    checks++;
    if (cnt_o[0] !== 4'd0 || flg[0][0] !== 1'b0 || flg[0][5] !== 1'b1) begin
      failures++;
      $display("FAIL flush_push count=%0d err=%b empty=%b exp 0 0 1", cnt_o[0], flg[0][0], flg[0][5]);
    end
  endtask

  task automatic test_wrap();
    int nxt, exp_v;
    do_reset();
    step(1, 0, 0, 1, 8'd1);
    step(1, 0, 0, 1, 8'd2);
    nxt = 3;
    exp_v = 1;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 1, 8'(nxt));
      nxt++;
      step(0, 1, 0, 1, 8'h00);
      checks++;
      if (dout[1] !== 8'(exp_v) || cnt_o[1] !== 4'd2) begin
        failures++;
        $display("FAIL wrap i=%0d dout=%h count=%0d exp %h 2", i, dout[1], cnt_o[1], 8'(exp_v));
      end
      exp_v++;
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 1, 8'h00);
      checks++;
      if (dout[1] !== 8'(exp_v)) begin
        failures++;
        $display("FAIL wrap_drain i=%0d got=%h exp=%h", i, dout[1], 8'(exp_v));
      end
      exp_v++;
    end
    checks++;
    if (flg[1][5] !== 1'b1) begin
      failures++;
      $display("FAIL wrap_empty got=%b exp=1", flg[1][5]);
    end
  endtask

  task automatic test_flags();
    logic [4:0] ef;
    ae = 4'd2;
    af = 4'd6;
    do_reset();
    for (int n = 0; n <= 8; n++) begin
      if (n > 0) step(1, 0, 0, 1, 8'(n));
      ef = {n == 0, n <= 2, n >= 4, n >= 6, n == 8};
      checks++;
      if (flg[2][5:1] !== ef) begin
        failures++;
        $display("FAIL flags n=%0d got=%b exp=%b", n, flg[2][5:1], ef);
      end
    end
  endtask

  task automatic test_show_ahead();
    do_reset();
    step(1, 0, 0, 1, 8'hA5);
    checks++;
    if (dout[2] !== 8'hA5 || flg[2][5] !== 1'b0) begin
      failures++;
      $display("FAIL show_ahead dout=%h empty=%b exp A5 0", dout[2], flg[2][5]);
    end
    step(1, 0, 0, 1, 8'hB6);
    step(1, 0, 0, 1, 8'hC7);
    do_reset();
    checks++;
    if (flg[2][5] !== 1'b1 || cnt_o[2] !== 4'd0) begin
      failures++;
      $display("FAIL rst_mid empty=%b count=%0d exp 1 0", flg[2][5], cnt_o[2]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        ae = 4'($urandom_range(0, 7));
        af = 4'($urandom_range(0, 7));
      end
      rst = ($urandom_range(0, 79) == 0);
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) != 0, 8'($urandom));
      rst = 0;
      for (int k = 0; k < 3; k++) begin
        int n;
        logic [5:0] ef;
        n = mq[k].size();
        ef = {n == 0, n <= int'(mae[k]), n >= (dep[k] + 1) / 2, n >= int'(maf[k]), n == dep[k], merr[k]};
        checks++;
        if (flg[k] !== ef || cnt_o[k] !== 4'(n)) begin
          failures++;
          $display("FAIL rand_state c=%0d k=%0d flags=%b count=%0d exp %b %0d", c, k, flg[k], cnt_o[k], ef, n);
        end
        if (sa[k] == 0 || n > 0) begin
          checks++;
          if (dout[k] !== ((sa[k] != 0) ? mq[k][0] : mdout[k])) begin
            failures++;
            $display("FAIL rand_dout c=%0d k=%0d got=%h exp=%h", c, k, dout[k], (sa[k] != 0) ? mq[k][0] : mdout[k]);
          end
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_err_sticky();
    test_err_pulse();
    test_simultaneous();
    test_wrap();
    test_flags();
    test_show_ahead();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
